operand_stage: RTL

Operand-fetch stage of the core, directly upstream of the ALU. It holds the 32-entry general register file, reads the two source registers of a decoded instruction, and selects the second operand: either the register or an extended immediate. It registers the operands, function code and destination into a single pipeline slot that drives the ALU `inA`/`inB`/`fx` inputs. A valid/ready handshake provides back-pressure, and a same-cycle write-through bypass lets writeback results reach dependent instructions without a stall.

---
 rtl/operand_stage_if.sv | 31 +++
 rtl/operand_stage.sv | 62 ++++++
 2 files changed

// File: rtl/operand_stage_if.sv
// operand_stage_if: decode-side handshake, writeback port and ALU-side slot outputs of the operand stage
interface operand_stage_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [15:0]       imm;
  logic              use_imm;
  logic              sign_ext;
  logic [3:0]        fx_in;
  logic [ADDR_W-1:0] dest_in;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] inA;
  logic [DATA_W-1:0] inB;
  logic [3:0]        fx;
  logic [ADDR_W-1:0] dest_out;
  modport master (
    output in_valid, rs_addr, rt_addr, imm, use_imm, sign_ext, fx_in, dest_in,
    output wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, inA, inB, fx, dest_out
  );
  modport slave (
    input  in_valid, rs_addr, rt_addr, imm, use_imm, sign_ext, fx_in, dest_in,
    input  wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, inA, inB, fx, dest_out
  );
endinterface

// File: rtl/operand_stage.sv
// operand_stage: register file with writeback bypass, operand B select and one-entry ALU pipeline slot
module operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic          clk,
  input logic          rst,
  operand_stage_if.slave bus
);
  logic [DATA_W-1:0] r_regs [2**ADDR_W];
  logic              r_valid;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [3:0]        r_fx;
  logic [ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0] w_rs;
  logic [DATA_W-1:0] w_rt;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_b;
  logic              w_ready;
  logic              w_accept;
  assign w_rs     = (bus.rs_addr == '0) ? '0 :
                    (bus.wb_en && bus.wb_addr == bus.rs_addr) ? bus.wb_data : r_regs[bus.rs_addr];
  assign w_rt     = (bus.rt_addr == '0) ? '0 :
                    (bus.wb_en && bus.wb_addr == bus.rt_addr) ? bus.wb_data : r_regs[bus.rt_addr];
  assign w_imm    = bus.sign_ext ? {{(DATA_W-16){bus.imm[15]}}, bus.imm} : {{(DATA_W-16){1'b0}}, bus.imm};
  assign w_b      = bus.use_imm ? w_imm : w_rt;
  assign w_ready  = !r_valid || bus.out_ready;
  assign w_accept = bus.in_valid && w_ready;
  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_valid;
  assign bus.inA       = r_a;
  assign bus.inB       = r_b;
  assign bus.fx        = r_fx;
  assign bus.dest_out  = r_dest;
  // register file: writes to r0 are dropped so it always reads back zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) r_regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != '0) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end
  // pipeline slot: load on accept, clear valid on consume, hold data otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_fx    <= '0;
      r_dest  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_a     <= w_rs;
      r_b     <= w_b;
      r_fx    <= bus.fx_in;
      r_dest  <= bus.dest_in;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule
